// File: rtl/dbgnoc_vc_packet_arbiter.sv
// Packet-atomic round-robin merge of the Debug NoC virtual channels
// into one registered flit stream for the host FIFO interface.
module dbgnoc_vc_packet_arbiter #(
    parameter int DBG_NOC_VCHANNELS       = 2,
    parameter int DBG_NOC_DATA_WIDTH      = 16,
    parameter int DBG_NOC_FLIT_TYPE_WIDTH = 2,
    parameter int PRIO_VCHANNEL           = 0,
    localparam int V  = DBG_NOC_VCHANNELS,
    localparam int DW = DBG_NOC_DATA_WIDTH,
    localparam int TW = DBG_NOC_FLIT_TYPE_WIDTH,
    localparam int FW = DW + TW,
    localparam int VW = $clog2(V)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [V*FW-1:0] in_flit,
    input  logic [V-1:0]    in_valid,
    output logic [V-1:0]    in_ready,
    output logic [FW-1:0]   out_flit,
    output logic [VW-1:0]   out_vc,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            hold,
    output logic            idle,
    output logic            err_misalign
);

    localparam logic [TW-1:0] T_PAYLOAD = TW'(0);
    localparam logic [TW-1:0] T_HEADER  = TW'(1);
    localparam logic [TW-1:0] T_SINGLE  = TW'(3);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   lock_q, lock_d;
    logic [VW-1:0]   rr_q, rr_d;
    logic            err_q, err_d;
    logic            out_valid_q, out_valid_d;
    logic [FW-1:0]   out_flit_q, out_flit_d;
    logic [VW-1:0]   out_vc_q, out_vc_d;

    logic [TW-1:0]   ty [V];
    logic [V-1:0]    ready;
    logic            load;
    logic            acc;
    logic [VW-1:0]   acc_vc;
    logic            drained;
    logic            found;
    logic [VW-1:0]   cand;
    logic [VW-1:0]   gnt;

    function automatic logic is_head(logic [TW-1:0] t);
        return (t == T_HEADER) || (t == T_SINGLE);
    endfunction

    function automatic logic [VW-1:0] wrap_add(logic [VW-1:0] b, int k);
        int s;
        s = int'(b) + k;
        if (s >= V) s = s - V;
        return VW'(s);
    endfunction

    always_comb begin
        for (int i = 0; i < V; i++) begin
            ty[i] = in_flit[i*FW+DW +: TW];
        end
    end

    assign load = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        rr_d        = rr_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        out_vc_d    = out_vc_q;
        ready       = '0;
        acc         = 1'b0;
        acc_vc      = lock_q;
        drained     = 1'b0;
        found       = 1'b0;
        cand        = '0;
        gnt         = rr_q;
        if (state_q == S_IDLE) begin
            // Drop one misaligned head per cycle so streams resync on a boundary
            for (int i = 0; i < V; i++) begin
                if (!drained && in_valid[i] && !is_head(ty[i])) begin
                    ready[i] = 1'b1;
                    drained  = 1'b1;
                    err_d    = 1'b1;
                end
            end
            for (int k = 0; k < V; k++) begin
                cand = wrap_add(rr_q, k);
                if (!found && in_valid[cand] && is_head(ty[cand])) begin
                    found = 1'b1;
                    gnt   = cand;
                end
            end
            if (found && !hold && load) begin
                ready[gnt] = 1'b1;
                acc        = 1'b1;
                acc_vc     = gnt;
                rr_d       = wrap_add(gnt, 1);
                if (ty[gnt] == T_HEADER) begin
                    state_d = S_LOCKED;
                    lock_d  = gnt;
                end
            end
        end else if (load && in_valid[lock_q]) begin
            ready[lock_q] = 1'b1;
            acc           = 1'b1;
            // A stray HEADER/SINGLE still closes the packet to avoid a stuck lock
            if (ty[lock_q] != T_PAYLOAD) state_d = S_IDLE;
            if (is_head(ty[lock_q])) err_d = 1'b1;
        end
        if (load) begin
            out_valid_d = acc;
            if (acc) begin
                out_flit_d = in_flit[int'(acc_vc)*FW +: FW];
                out_vc_d   = acc_vc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lock_q      <= '0;
            rr_q        <= VW'(PRIO_VCHANNEL);
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_vc_q    <= '0;
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            rr_q        <= rr_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_vc_q    <= out_vc_d;
        end
    end

    assign in_ready     = rst ? '0 : ready;
    assign out_flit     = out_flit_q;
    assign out_vc       = out_vc_q;
    assign out_valid    = out_valid_q;
    assign idle         = (state_q == S_IDLE) && !out_valid_q;
    assign err_misalign = err_q;

endmodule

// File: tb/tb_dbgnoc_vc_packet_arbiter.sv
// Directed bench for dbgnoc_vc_packet_arbiter: vector table plus
// queue-driven packet sequences for multi-cycle corner cases.
module tb_dbgnoc_vc_packet_arbiter;

    localparam int FW = 18;
    typedef logic [FW-1:0] flit_t;

    localparam logic  Z  = 1'b0;
    localparam logic  O  = 1'b1;
    localparam flit_t F0 = '0;
    localparam flit_t S_A5   = 18'h3A5A5;
    localparam flit_t P_1234 = 18'h01234;
    localparam flit_t S_BE   = 18'h3BEEF;
    localparam flit_t S_11   = 18'h31111;
    localparam flit_t S_22   = 18'h32222;

    logic            clk = 1'b0;
    logic            rst;
    logic [2*FW-1:0] in_flit;
    logic [1:0]      in_valid;
    logic [1:0]      in_ready;
    flit_t           out_flit;
    logic            out_vc;
    logic            out_valid;
    logic            out_ready;
    logic            hold;
    logic            idle;
    logic            err_misalign;

    dbgnoc_vc_packet_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .in_flit      (in_flit),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_flit     (out_flit),
        .out_vc       (out_vc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .hold         (hold),
        .idle         (idle),
        .err_misalign (err_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] vld;
        flit_t      f0;
        flit_t      f1;
        logic       ordy;
        logic       hold;
        logic [1:0] ir;
        logic       ov;
        flit_t      flit;
        logic       vc;
        logic       idl;
        logic       err;
    } vec_t;

    vec_t  tbl [13];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    flit_t q0[$], q1[$], rec_f[$], expf[$];
    int    rec_vc[$], rec_cyc[$];

    logic [1:0] cap_ir;
    logic       cap_ov, cap_vc, cap_idle, cap_err;
    flit_t      cap_flit;

    function automatic flit_t mk(logic [1:0] t, logic [15:0] d);
        return {t, d};
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        #1;
        cap_ir   = in_ready;
        cap_ov   = out_valid;
        cap_flit = out_flit;
        cap_vc   = out_vc;
        cap_idle = idle;
        cap_err  = err_misalign;
        @(posedge clk);
        if (cap_ir[0] && in_valid[0] && q0.size() > 0) void'(q0.pop_front());
        if (cap_ir[1] && in_valid[1] && q1.size() > 0) void'(q1.pop_front());
        if (cap_ov && out_ready) begin
            rec_f.push_back(cap_flit);
            rec_vc.push_back(int'(cap_vc));
            rec_cyc.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic step();
        in_valid[0]        = (q0.size() != 0);
        in_valid[1]        = (q1.size() != 0);
        in_flit[FW-1:0]    = (q0.size() != 0) ? q0[0] : F0;
        in_flit[2*FW-1:FW] = (q1.size() != 0) ? q1[0] : F0;
        tick();
    endtask

    task automatic do_reset();
        q0.delete();
        q1.delete();
        in_valid  = 2'b00;
        in_flit   = '0;
        hold      = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        rec_f.delete();
        rec_vc.delete();
        rec_cyc.delete();
    endtask

    task automatic check_rec(string name, int vc0_count);
        check({name, "_n"}, rec_f.size(), expf.size());
        for (int k = 0; k < expf.size(); k++) begin
            if (k < rec_f.size()) begin
                check({name, "_flit"}, rec_f[k], expf[k]);
                check({name, "_vc"}, rec_vc[k], (k < vc0_count) ? 0 : 1);
            end
        end
    endtask

    initial begin
        tbl[0]  = '{O, 2'b11, S_A5, S_A5, O, Z, 2'b00, Z, F0, Z, O, Z};
        tbl[1]  = '{Z, 2'b01, S_A5, F0, O, Z, 2'b01, Z, F0, Z, O, Z};
        tbl[2]  = '{Z, 2'b00, F0, F0, O, Z, 2'b00, O, S_A5, Z, Z, Z};
        tbl[3]  = '{Z, 2'b00, F0, F0, O, Z, 2'b00, Z, S_A5, Z, O, Z};
        tbl[4]  = '{Z, 2'b01, P_1234, F0, O, Z, 2'b01, Z, S_A5, Z, O, Z};
        tbl[5]  = '{Z, 2'b00, F0, F0, O, Z, 2'b00, Z, S_A5, Z, O, O};
        tbl[6]  = '{Z, 2'b10, F0, S_BE, O, O, 2'b00, Z, S_A5, Z, O, O};
        tbl[7]  = '{Z, 2'b10, F0, S_BE, O, Z, 2'b10, Z, S_A5, Z, O, O};
        tbl[8]  = '{Z, 2'b11, S_11, S_22, Z, Z, 2'b00, O, S_BE, O, Z, O};
        tbl[9]  = '{Z, 2'b11, S_11, S_22, O, Z, 2'b01, O, S_BE, O, Z, O};
        tbl[10] = '{Z, 2'b10, F0, S_22, O, Z, 2'b10, O, S_11, Z, Z, O};
        tbl[11] = '{Z, 2'b00, F0, F0, O, Z, 2'b00, O, S_22, O, Z, O};
        tbl[12] = '{Z, 2'b00, F0, F0, O, Z, 2'b00, Z, S_22, O, O, O};

        rst       = 1'b1;
        in_valid  = 2'b00;
        in_flit   = '0;
        out_ready = 1'b1;
        hold      = 1'b0;
        @(negedge clk);
        tick();

        for (int i = 0; i < 13; i++) begin
            rst       = tbl[i].rst;
            in_valid  = tbl[i].vld;
            in_flit   = {tbl[i].f1, tbl[i].f0};
            out_ready = tbl[i].ordy;
            hold      = tbl[i].hold;
            tick();
            check($sformatf("v%0d_in_ready", i), cap_ir, tbl[i].ir);
            check($sformatf("v%0d_out_valid", i), cap_ov, tbl[i].ov);
            check($sformatf("v%0d_out_flit", i), cap_flit, tbl[i].flit);
            check($sformatf("v%0d_out_vc", i), cap_vc, tbl[i].vc);
            check($sformatf("v%0d_idle", i), cap_idle, tbl[i].idl);
            check($sformatf("v%0d_err", i), cap_err, tbl[i].err);
        end

        // Atomicity: vc0 H,P,P,L then vc1 H,L
        do_reset();
        q0 = '{mk(2'b01, 16'h0A01), mk(2'b00, 16'h0A02),
               mk(2'b00, 16'h0A03), mk(2'b10, 16'h0A04)};
        q1 = '{mk(2'b01, 16'h0B01), mk(2'b10, 16'h0B02)};
        expf = {q0, q1};
        repeat (10) step();
        check_rec("atom", 4);
        check("atom_err", cap_err, 0);

        // Round-robin: back-to-back SINGLEs on both channels
        do_reset();
        q0.delete();
        q1.delete();
        expf.delete();
        for (int k = 0; k < 4; k++) begin
            q0.push_back(mk(2'b11, 16'h1000 + 16'(k)));
            q1.push_back(mk(2'b11, 16'h2000 + 16'(k)));
        end
        for (int k = 0; k < 4; k++) begin
            expf.push_back(q0[k]);
            expf.push_back(q1[k]);
        end
        repeat (12) step();
        check("rr_n", rec_f.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < rec_f.size()) begin
                check("rr_vc", rec_vc[k], k % 2);
                check("rr_flit", rec_f[k], expf[k]);
            end
        end
        if (rec_cyc.size() == 8)
            check("rr_span", rec_cyc[7] - rec_cyc[0], 7);

        // Backpressure: 5-cycle stall mid-packet
        do_reset();
        q0 = '{mk(2'b01, 16'hC001), mk(2'b00, 16'hC002), mk(2'b00, 16'hC003),
               mk(2'b00, 16'hC004), mk(2'b10, 16'hC005)};
        expf = q0;
        step();
        step();
        out_ready = 1'b0;
        repeat (5) begin
            step();
            check("bp_in_ready", cap_ir, 2'b00);
            check("bp_out_valid", cap_ov, 1);
            check("bp_out_flit", cap_flit, mk(2'b00, 16'hC002));
        end
        out_ready = 1'b1;
        repeat (8) step();
        check_rec("bp", 5);

        // Hold asserted mid-packet on vc1, vc0 HEADER must wait
        do_reset();
        q1 = '{mk(2'b01, 16'hD001), mk(2'b00, 16'hD002),
               mk(2'b00, 16'hD003), mk(2'b10, 16'hD004)};
        step();
        hold = 1'b1;
        q0.push_back(mk(2'b01, 16'hD101));
        repeat (5) step();
        check("hold_blocked", q0.size(), 1);
        check("hold_idle", cap_idle, 1);
        check("hold_pkt_n", rec_f.size(), 4);
        if (rec_f.size() == 4) check("hold_last", rec_f[3], mk(2'b10, 16'hD004));
        hold = 1'b0;
        repeat (3) step();
        check("hold_release_q", q0.size(), 0);
        check("hold_release_n", rec_f.size(), 5);
        if (rec_f.size() == 5) check("hold_release_vc", rec_vc[4], 0);

        // HEADER/SINGLE inside a packet closes it and flags an error
        do_reset();
        q0 = '{mk(2'b01, 16'hE001), mk(2'b11, 16'hE002)};
        q1 = '{mk(2'b11, 16'hE003)};
        expf = {q0, q1};
        repeat (5) step();
        check_rec("proto", 2);
        check("proto_err", cap_err, 1);

        // Reset mid-packet: output drops, leftovers drained
        do_reset();
        q0 = '{mk(2'b01, 16'hF001), mk(2'b00, 16'hF002),
               mk(2'b00, 16'hF003), mk(2'b10, 16'hF004)};
        step();
        step();
        check("rst_pre_ov", cap_ov, 1);
        rst = 1'b1;
        step();
        check("rst_in_ready", cap_ir, 2'b00);
        rst = 1'b0;
        rec_f.delete();
        rec_vc.delete();
        step();
        check("rst_out_valid", cap_ov, 0);
        check("rst_idle", cap_idle, 1);
        check("rst_drain", cap_ir, 2'b01);
        check("rst_err_clr", cap_err, 0);
        repeat (3) step();
        check("rst_q_empty", q0.size(), 0);
        check("rst_no_out", rec_f.size(), 0);
        check("rst_err", cap_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
